// File: rtl/cic_pkg.sv
// Shared types and sizing helpers for the time-multiplexed CIC comb section.
package cic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } comb_state_e;

  // Stage index width: $clog2(STAGES), never narrower than one bit.
  function automatic int idx_width(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

  function automatic int cnt_width(input int decim);
    return (decim > 1) ? $clog2(decim) : 1;
  endfunction

endpackage

// File: rtl/cic_delay_bank.sv
// STAGES x WIDTH comb delay words: one asynchronous read port and one
// synchronous write port sharing the stage index, async clear of every word.
module cic_delay_bank
  import cic_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 3,
  localparam int IW     = idx_width(STAGES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we_i,
  input  logic [IW-1:0]    idx_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [STAGES];

  // Delay word storage; only the addressed word is written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) begin
        mem_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (we_i && (idx_i == IW'(s))) begin
          mem_q[s] <= wdata_i;
        end
      end
    end
  end

  // Read mux; an index past STAGES-1 cannot occur and reads as zero.
  always_comb begin
    rdata_o = '0;
    for (int s = 0; s < STAGES; s++) begin
      rdata_o = (idx_i == IW'(s)) ? mem_q[s] : rdata_o;
    end
  end

endmodule

// File: rtl/cic_comb_sequencer.sv
// Serial CIC comb section: decimates by DECIM, then runs STAGES comb differences
// through one shared subtractor. Optional CIC_COMB_OVERRUN_EN adds overrun/clr_ovr.
module cic_comb_sequencer
  import cic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int DECIM  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x_in,
  output logic [WIDTH-1:0] y_out,
  output logic             out_valid,
`ifdef CIC_COMB_OVERRUN_EN
  output logic             overrun,
  input  logic             clr_ovr,
`endif
  output logic             busy
);

  localparam int IW = idx_width(STAGES);
  localparam int CW = cnt_width(DECIM);
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(STAGES - 1);

  comb_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ov_q, ov_d;

  logic             accept_s;
  logic             hit_s;
  logic             drop_s;
  logic             dly_we_s;
  logic [WIDTH-1:0] dly_rd_s;
  logic [WIDTH-1:0] diff_s;

  assign accept_s = ena & in_valid;
  assign hit_s    = accept_s & (cnt_q == CNT_LAST);
  // A hit on any RUN cycle, including the last one, is lost.
  assign drop_s   = hit_s & (state_q == RUN);
  assign dly_we_s = ena & (state_q == RUN);
  assign diff_s   = acc_q - dly_rd_s;

  cic_delay_bank #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_delay_bank (
    .clock   (clock),
    .reset   (reset),
    .we_i    (dly_we_s),
    .idx_i   (idx_q),
    .wdata_i (acc_q),
    .rdata_o (dly_rd_s)
  );

  // State, counter and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state logic: decimation count, comb sequencing and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    y_d     = y_q;
    ov_d    = 1'b0;

    if (accept_s) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    if (ena) begin
      case (state_q)
        IDLE: begin
          if (hit_s) begin
            acc_d   = x_in;
            idx_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          acc_d = diff_s;
          if (idx_q == IDX_LAST) begin
            y_d     = diff_s;
            ov_d    = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign y_out     = y_q;
  assign out_valid = ov_q;
  assign busy      = (state_q == RUN);

`ifdef CIC_COMB_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Sticky overrun; a simultaneous drop beats the clear. The clear is a
  // control-plane action and works whether or not ena is high.
  always_comb begin
    if (drop_s) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun = ovr_q;
`endif

endmodule
